comparador_serial: RTL and testbench
====================================

Name: comparador_serial

Overview:
- Sequential, parametrised magnitude comparator; successor to the combinational 7485-style comparator.
- Compares two WIDTH-bit operands DIGIT bits per clock, MSB digit first.
- Stops on the first differing digit.
- Supports unsigned and two's-complement modes, and keeps the 7485 cascade inputs for chaining.
- Used in the datapath wherever operands are too wide for a single-cycle comparison, or where a start/done handshake with the control unit is wanted.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits compared per clock cycle. 1 ≤ DIGIT ≤ WIDTH.
- NDIG, WIDTH/DIGIT: number of digits. Derived; never overridden.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset (0 = reset).
- iniciar, in, 1: start request, sampled on the clock edge.
- A, in, WIDTH: operand A, captured when a start is accepted.
- B, in, WIDTH: operand B, captured when a start is accepted.
- sinal, in, 1: 1 = two's-complement compare, 0 = unsigned. Captured on start.
- ALBi, in, 1: cascade input "A<B", captured on start.
- AGBi, in, 1: cascade input "A>B", captured on start.
- AEBi, in, 1: cascade input "A=B", captured on start.
- ocupado, out, 1: high while a comparison is in progress.
- pronto, out, 1: one-cycle pulse when the result becomes valid.
- ALBo, out, 1: result A<B.
- AGBo, out, 1: result A>B.
- AEBo, out, 1: result A=B.
- ciclos, out, clog2(NDIG)+1: number of digits examined in the last comparison.

Behaviour:

Reset (reset=0, asynchronous):
- State goes to INICIAL.
- ocupado=0, pronto=0, ALBo=AGBo=AEBo=0, ciclos=0.
- Internal operand, index and cascade registers are cleared.
- Reset asserted mid-comparison aborts it; no pronto is produced.

States:
- INICIAL
  - Idle.
  - iniciar=1: capture A, B, sinal, ALBi/AGBi/AEBi; set idx=NDIG-1, cnt=0; go to COMPARA.
- COMPARA
  - ocupado=1; iniciar is ignored.
  - Each cycle, compare digit idx of the captured A and B (bits idx*DIGIT+DIGIT-1 down to idx*DIGIT); cnt increments.
  - Signed mode: on the top digit only, invert the MSB of both operands (offset-binary) before an unsigned digit compare.
  - Digits differ: register ALBo/AGBo from that digit, AEBo=0; go to FIM.
  - Digits equal and idx>0: idx decrements; stay in COMPARA.
  - Digits equal and idx=0: operands are fully equal, so ALBo=ALBi, AGBo=AGBi, AEBo=AEBi (copied from the captured cascade inputs, any combination passed through); go to FIM.
- FIM
  - pronto=1 for exactly the first cycle in FIM; ocupado=0.
  - ALBo/AGBo/AEBo/ciclos hold until the next accepted start.
  - iniciar=1: capture and go to COMPARA (back-to-back allowed, including in the pronto cycle).
  - No iniciar: stay in FIM with results held.

Timing:
- Outputs are registered; no combinational path from inputs to outputs.
- iniciar is accepted at edge E0. The digit compares occur at edges E1..Ed, where d = digits examined, 1 ≤ d ≤ NDIG.
- Results, ciclos=d and pronto=1 are visible after edge Ed. Latency is therefore d cycles.
- ciclos is updated together with the results.
- On a new start, the result outputs are cleared to 0 at E0 and stay 0 until the new result.

Boundary conditions:
- DIGIT=WIDTH: single-cycle compare (NDIG=1); the signed fix applies to that single digit.
- A=B: always takes NDIG cycles.
- The top digit already decides: 1 cycle.
- Changes on the A, B or cascade inputs after capture have no effect on the comparison in progress.
- Signed mode with A=B: result depends only on the cascade inputs.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
1. A=B=0x1234, sinal=0, AEBi=1, ALBi=AGBi=0 → pronto 4 cycles after start; AEBo=1, ALBo=AGBo=0, ciclos=4.
2. A=0x8000, B=0x7FFF:
   - sinal=0 → AGBo=1 after 1 cycle, ciclos=1.
   - sinal=1 → ALBo=1, ciclos=1.
3. A=0x12F0, B=0x12E0, sinal=0 → AGBo=1, ciclos=3; pronto high exactly one cycle, results held 10 further idle cycles.
4. A=B=0xFFFF, cascade ALBi=1, AGBi=0, AEBi=0 → ALBo=1, AEBo=0, ciclos=4. Repeat with all cascade inputs 0 → all outputs 0.
5. Start A=0x0001, B=0x0002:
   - Pulse iniciar again with new operands at cycle 2 → ignored; ALBo=1, ciclos=4.
   - Then reset=0 at cycle 2 of a new compare → outputs 0 immediately, state INICIAL, no pronto.
6. iniciar held in the pronto cycle with A=0xFFFF, B=0x0000, sinal=1 → new compare starts; ALBo=1, ciclos=1. Also WIDTH=6, DIGIT=6: A=6'd5, B=6'd9 → ALBo=1 after 1 cycle.

Source files
------------

// File: rtl/comparador_serial.sv
// comparador_serial: sequential magnitude comparator that walks two WIDTH-bit
// operands DIGIT bits per clock, MSB digit first, and stops on the first
// differing digit. Unsigned or two's-complement, with 7485-style cascade
// inputs that decide the result when the operands are fully equal.
module comparador_serial #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic [WIDTH-1:0]        A,
  input  logic [WIDTH-1:0]        B,
  input  logic                    sinal,
  input  logic                    ALBi,
  input  logic                    AGBi,
  input  logic                    AEBi,
  output logic                    ocupado,
  output logic                    pronto,
  output logic                    ALBo,
  output logic                    AGBo,
  output logic                    AEBo,
  output logic [$clog2(NDIG):0]   ciclos
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {
    INICIAL,
    COMPARA,
    FIM
  } estado_t;

  estado_t           estado_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              sinal_q;
  logic              alb_q;
  logic              agb_q;
  logic              aeb_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     cnt_q;
  logic              ocupado_q;
  logic              pronto_q;
  logic              albo_q;
  logic              agbo_q;
  logic              aebo_q;
  logic [CW-1:0]     ciclos_q;

  logic [DIGIT-1:0]  dig_a;
  logic [DIGIT-1:0]  dig_b;
  logic [CW-1:0]     cnt_d;
  logic              topo;

  // Select the current digit; in signed mode the top digit is compared in
  // offset-binary (MSB inverted) so a plain unsigned compare orders it.
  always_comb begin
    dig_a = a_q[int'(idx_q) * DIGIT +: DIGIT];
    dig_b = b_q[int'(idx_q) * DIGIT +: DIGIT];
    topo  = (idx_q == IW'(NDIG - 1));
    if (sinal_q && topo) begin
      dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
      dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
    end
    cnt_d = cnt_q + CW'(1);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      a_q       <= '0;
      b_q       <= '0;
      sinal_q   <= 1'b0;
      alb_q     <= 1'b0;
      agb_q     <= 1'b0;
      aeb_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      albo_q    <= 1'b0;
      agbo_q    <= 1'b0;
      aebo_q    <= 1'b0;
      ciclos_q  <= '0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        INICIAL, FIM: begin
          if (iniciar) begin
            a_q       <= A;
            b_q       <= B;
            sinal_q   <= sinal;
            alb_q     <= ALBi;
            agb_q     <= AGBi;
            aeb_q     <= AEBi;
            idx_q     <= IW'(NDIG - 1);
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            albo_q    <= 1'b0;
            agbo_q    <= 1'b0;
            aebo_q    <= 1'b0;
            ciclos_q  <= '0;
            estado_q  <= COMPARA;
          end
        end
        COMPARA: begin
          cnt_q <= cnt_d;
          if (dig_a != dig_b) begin
            albo_q    <= (dig_a < dig_b);
            agbo_q    <= (dig_a > dig_b);
            aebo_q    <= 1'b0;
            ciclos_q  <= cnt_d;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= FIM;
          end else if (idx_q == '0) begin
            albo_q    <= alb_q;
            agbo_q    <= agb_q;
            aebo_q    <= aeb_q;
            ciclos_q  <= cnt_d;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= FIM;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign ALBo    = albo_q;
  assign AGBo    = agbo_q;
  assign AEBo    = aebo_q;
  assign ciclos  = ciclos_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Bench for comparador_serial: directed scenarios plus randomized compares
// against an arithmetic reference model.
module tb_comparador_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar, sinal, ALBi, AGBi, AEBi;
  logic [15:0] A, B;
  logic        ocupado, pronto, ALBo, AGBo, AEBo;
  logic [2:0]  ciclos;

  logic        iniciar6, sinal6, ALBi6, AGBi6, AEBi6;
  logic [5:0]  A6, B6;
  logic        ocupado6, pronto6, ALBo6, AGBo6, AEBo6;
  logic [0:0]  ciclos6;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  comparador_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .A(A), .B(B),
    .sinal(sinal), .ALBi(ALBi), .AGBi(AGBi), .AEBi(AEBi),
    .ocupado(ocupado), .pronto(pronto), .ALBo(ALBo), .AGBo(AGBo),
    .AEBo(AEBo), .ciclos(ciclos)
  );

  comparador_serial #(.WIDTH(6), .DIGIT(6)) dut6 (
    .clock(clock), .reset(reset), .iniciar(iniciar6), .A(A6), .B(B6),
    .sinal(sinal6), .ALBi(ALBi6), .AGBi(AGBi6), .AEBi(AEBi6),
    .ocupado(ocupado6), .pronto(pronto6), .ALBo(ALBo6), .AGBo(AGBo6),
    .AEBo(AEBo6), .ciclos(ciclos6)
  );

  // Reference: arithmetic compare; digits examined = digits down to and
  // including the one holding the highest differing bit.
  function automatic logic [5:0] model(input int w, input int dg,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input logic lb,
                                       input logic gb, input logic eb);
    longint va, vb;
    int     hb, d;
    logic   lt, gt, eq;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    hb = -1;
    for (int i = 0; i < w; i++) if (a[i] !== b[i]) hb = i;
    if (hb < 0) begin
      d = w / dg; lt = lb; gt = gb; eq = eb;
    end else begin
      d = w / dg - hb / dg; lt = (va < vb); gt = (va > vb); eq = 1'b0;
    end
    return {lt, gt, eq, 3'(d)};
  endfunction

  function automatic logic [5:0] res16();
    return {ALBo, AGBo, AEBo, ciclos};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic lb, input logic gb, input logic eb);
    A = a; B = b; sinal = s; ALBi = lb; AGBi = gb; AEBi = eb;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Waits (bounded) for pronto; lat = cycles after the accepting edge, -1 on timeout.
  task automatic wait_pronto(input bit scramble, output int lat);
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      if (scramble) begin
        A = 16'($urandom); B = 16'($urandom); sinal = 1'($urandom);
        ALBi = 1'($urandom); AGBi = 1'($urandom); AEBi = 1'($urandom);
        iniciar = 1'($urandom);
      end
      tick();
      if (pronto) begin
        lat = n;
        break;
      end
    end
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    vectors++;
    if ({ocupado, pronto, ALBo, AGBo, AEBo, ciclos} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset16 got %h exp 00", {ocupado, pronto, ALBo, AGBo, AEBo, ciclos});
    end
    vectors++;
    if ({ocupado6, pronto6, ALBo6, AGBo6, AEBo6, ciclos6} !== 6'h00) begin
      miscompares++;
      $display("FAIL reset6 got %h exp 00", {ocupado6, pronto6, ALBo6, AGBo6, AEBo6, ciclos6});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_equal();
    int lat;
    logic [5:0] e;
    start(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({ocupado, ALBo, AGBo, AEBo} !== 4'b1000) begin
      miscompares++;
      $display("FAIL equal_busy got %b exp 1000", {ocupado, ALBo, AGBo, AEBo});
    end
    wait_pronto(1'b0, lat);
    e = model(16, 4, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL equal_latency got %0d exp 4", lat);
    end
    vectors++;
    if (res16() !== e) begin
      miscompares++;
      $display("FAIL equal_result got %b exp %b", res16(), e);
    end
  endtask

  task automatic test_top_digit();
    int lat;
    logic [5:0] e;
    for (int s = 0; s < 2; s++) begin
      tick();
      start(16'h8000, 16'h7FFF, 1'(s), 1'b0, 1'b0, 1'b1);
      wait_pronto(1'b0, lat);
      e = model(16, 4, 32'h8000, 32'h7FFF, 1'(s), 1'b0, 1'b0, 1'b1);
      vectors++;
      if (lat !== 1 || res16() !== e) begin
        miscompares++;
        $display("FAIL top_digit s=%0d got lat=%0d res=%b exp lat=1 res=%b", s, lat, res16(), e);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [5:0] e;
    tick();
    start(16'h12F0, 16'h12E0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_pronto(1'b0, lat);
    e = model(16, 4, 32'h12F0, 32'h12E0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (lat !== 3 || res16() !== e || ocupado !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_result got lat=%0d res=%b busy=%b exp lat=3 res=%b busy=0",
               lat, res16(), ocupado, e);
    end
    for (int n = 0; n < 10; n++) begin
      A = 16'($urandom); B = 16'($urandom);
      tick();
      vectors++;
      if (pronto !== 1'b0 || res16() !== e) begin
        miscompares++;
        $display("FAIL hold_idle n=%0d got pronto=%b res=%b exp pronto=0 res=%b",
                 n, pronto, res16(), e);
      end
    end
  endtask

  task automatic test_cascade();
    int lat;
    logic [5:0] e;
    logic [2:0] c;
    logic s;
    for (int k = 0; k < 8; k++) begin
      c = (k == 0) ? 3'b100 : (k == 1) ? 3'b000 : 3'(k);
      s = (k < 2) ? 1'b0 : 1'($urandom);
      tick();
      start(16'hFFFF, 16'hFFFF, s, c[2], c[1], c[0]);
      wait_pronto(1'b0, lat);
      e = model(16, 4, 32'hFFFF, 32'hFFFF, s, c[2], c[1], c[0]);
      vectors++;
      if (lat !== 4 || res16() !== e) begin
        miscompares++;
        $display("FAIL cascade c=%b s=%b got lat=%0d res=%b exp lat=4 res=%b",
                 c, s, lat, res16(), e);
      end
    end
  endtask

  task automatic test_ignore_and_reset();
    int lat;
    logic [5:0] e;
    bit saw;
    tick();
    start(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      if (n == 2) begin
        A = 16'hFFFF; B = 16'h0000; iniciar = 1'b1;
      end else begin
        iniciar = 1'b0;
      end
      tick();
      if (pronto) begin
        lat = n;
        break;
      end
    end
    iniciar = 1'b0;
    e = model(16, 4, 32'h0001, 32'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lat !== 4 || res16() !== e) begin
      miscompares++;
      $display("FAIL ignore_start got lat=%0d res=%b exp lat=4 res=%b", lat, res16(), e);
    end
    tick();
    start(16'h00F0, 16'h00F1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({ocupado, pronto, ALBo, AGBo, AEBo, ciclos} !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset got %h exp 00", {ocupado, pronto, ALBo, AGBo, AEBo, ciclos});
    end
    @(negedge clock);
    reset = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (pronto || ocupado) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort got activity=%b exp 0", saw);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [5:0] e;
    tick();
    start(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_pronto(1'b0, lat);
    e = model(16, 4, 32'h0003, 32'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lat !== 4 || res16() !== e) begin
      miscompares++;
      $display("FAIL b2b_first got lat=%0d res=%b exp lat=4 res=%b", lat, res16(), e);
    end
    start(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({ocupado, pronto, ALBo, AGBo, AEBo} !== 5'b10000) begin
      miscompares++;
      $display("FAIL b2b_restart got %b exp 10000", {ocupado, pronto, ALBo, AGBo, AEBo});
    end
    wait_pronto(1'b0, lat);
    e = model(16, 4, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lat !== 1 || res16() !== e) begin
      miscompares++;
      $display("FAIL b2b_second got lat=%0d res=%b exp lat=1 res=%b", lat, res16(), e);
    end
  endtask

  task automatic test_single_digit();
    int lat;
    logic [5:0] e;
    logic [5:0] a, b;
    logic s, lb, gb, eb;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        a = 6'd5; b = 6'd9; s = 1'b0; lb = 1'b0; gb = 1'b0; eb = 1'b1;
      end else begin
        a = 6'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 6'($urandom);
        s = 1'($urandom); lb = 1'($urandom); gb = 1'($urandom); eb = 1'($urandom);
      end
      A6 = a; B6 = b; sinal6 = s; ALBi6 = lb; AGBi6 = gb; AEBi6 = eb;
      iniciar6 = 1'b1;
      tick();
      iniciar6 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 4; n++) begin
        A6 = 6'($urandom); B6 = 6'($urandom);
        tick();
        if (pronto6) begin
          lat = n;
          break;
        end
      end
      e = model(6, 6, 32'(a), 32'(b), s, lb, gb, eb);
      vectors++;
      if (lat !== 1 || {ALBo6, AGBo6, AEBo6, 2'b00, ciclos6} !== e) begin
        miscompares++;
        $display("FAIL single_digit a=%h b=%h s=%b got lat=%0d res=%b exp lat=1 res=%b",
                 a, b, s, lat, {ALBo6, AGBo6, AEBo6, 2'b00, ciclos6}, e);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [5:0] e;
    logic [15:0] a, b;
    logic s, lb, gb, eb;
    for (int k = 0; k < 200; k++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (16'h0001 << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      s = 1'($urandom); lb = 1'($urandom); gb = 1'($urandom); eb = 1'($urandom);
      if ($urandom_range(0, 1) == 0) tick();
      start(a, b, s, lb, gb, eb);
      wait_pronto(1'b1, lat);
      e = model(16, 4, 32'(a), 32'(b), s, lb, gb, eb);
      vectors++;
      if (lat !== int'(e[2:0]) || res16() !== e) begin
        miscompares++;
        $display("FAIL random a=%h b=%h s=%b got lat=%0d res=%b exp lat=%0d res=%b",
                 a, b, s, lat, res16(), int'(e[2:0]), e);
      end
    end
  endtask

  initial begin
    iniciar = 1'b0; sinal = 1'b0; ALBi = 1'b0; AGBi = 1'b0; AEBi = 1'b0;
    A = '0; B = '0;
    iniciar6 = 1'b0; sinal6 = 1'b0; ALBi6 = 1'b0; AGBi6 = 1'b0; AEBi6 = 1'b0;
    A6 = '0; B6 = '0;
    test_reset();
    test_equal();
    test_top_digit();
    test_hold();
    test_cascade();
    test_ignore_and_reset();
    test_back_to_back();
    test_single_digit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
